irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//   Interrupt aggregator sitting between the peripherals (ACIA IRQn, VIA O_IRQ_L, board pins) and the 65C02 IRQ input.
//   Latches/masks up to N_SRC sources, resolves a fixed priority, drives one active-low IRQ to the CPU.
//   CPU-mapped register window (8 regs), accessed with the same cpu_clken-qualified bus as RAM/ACIA/VIA.
// PARAMETERS
//   N_SRC      8   number of interrupt sources (1..8); unused STATUS/ENABLE/MODE bits read 0
// PORTS
//   clk        in   1      system clock (single clock domain)
//   resb       in   1      asynchronous active-low reset
//   cpu_clken  in   1      CPU bus strobe; register writes take effect only when high
//   sel        in   1      chip select (address decode done in top)
//   we         in   1      1 = write, 0 = read (registered cpu_we)
//   addr       in   3      register offset (cpu_addr[2:0])
//   din        in   8      write data (registered cpu_dout)
//   dout       out  8      read data, registered
//   src        in   N_SRC  interrupt sources, active-high (top inverts active-low IRQs)
//   irq_n      out  1      active-low interrupt to CPU, registered
// BEHAVIOUR
//   Reset: all registers 0; irq_n=1; dout=0x00; VECTOR reads 0x80.
//   Register map (offset: name, access):
//     0 STATUS  R / W1C   bit i = pending[i]
//     1 ENABLE  RW        per-source mask, 1 = enabled
//     2 MODE    RW        1 = rising-edge latched, 0 = level (unlatched)
//     3 ACTIVE  R         STATUS & ENABLE
//     4 VECTOR  R: {none,4'b0,idx}; W: clears edge pending[din[2:0]]
//     5 CTRL    RW        bit0 = global enable GIE; bits 7:1 read 0
//     6,7       read 0x00, writes ignored
//   Write strobe wr = sel & we & cpu_clken; exactly one register update per strobe.
//   Sampling: src sampled every clk (not gated by cpu_clken); s_d = previous sample.
//   Edge source: pending set on s & ~s_d; cleared by W1C STATUS or VECTOR write; set and clear same clk -> set wins.
//   Level source: pending = current sample; W1C has no effect.
//   MODE write 1->0 clears that source's edge pending flop in the same clk.
//   Priority: lowest index wins; idx = lowest set bit of ACTIVE; none = (ACTIVE==0); none -> idx=0.
//   irq_n <= ~(GIE & |ACTIVE); one clk after ACTIVE/GIE change; level-style, CPU must clear source.
//   dout <= register[addr] every clk regardless of sel/cpu_clken; reads have no side effects.
//     1-clk read latency; data valid before next cpu_clken (addr held 4 clks).
//   Latency src edge -> irq_n low: 2 clks (sample, pending) + 1 (irq_n) = 3 clks without sync.
//   Writes to ENABLE/CTRL mid-pending: irq_n follows on next clk; pending preserved.
//   Async reset mid-operation clears pending and drops irq_n high immediately.
// CONFIGURATION
//   IRQ_CTRL_SYNC_EN defined: two-flop synchronizer ahead of sampling on every src bit.
//     Adds 2 clks to all src latencies (edge -> irq_n = 5 clks); for raw board pins.
//   Not defined: single sample flop only; src must already be synchronous to clk.
// STRUCTURE
//   irq_ctrl_pkg: register offset localparams (IRQ_STATUS..IRQ_CTRL), IRQ_MAX_SRC=8,
//     VECTOR_NONE=8'h80, typedef logic [7:0] irq_vec_t.
//   Sub-module irq_src_cell (one per source, generate loop): sync (macro-dependent),
//     sample flop, edge detect, pending flop with set/clear/mode inputs.
//   irq_ctrl: register file, priority encoder, read mux, irq_n flop.
// TESTING
//   Reset: resb low -> irq_n=1, all regs 0, VECTOR=0x80; release, no src -> irq_n stays 1.
//   Edge: MODE=0x01, ENABLE=0x01, GIE=1, pulse src[0] 1 clk -> irq_n low 3 clks later;
//     STATUS=0x01; write STATUS 0x01 -> irq_n high next clk.
//   Level: MODE=0, ENABLE=0x04, GIE=1, src[2] high -> VECTOR=0x02;
//     W1C ignored; src[2] low -> irq_n high after 2 clks.
//   Priority: src[5] and src[3] edge, all enabled -> VECTOR=0x03;
//     write VECTOR 0x03 -> VECTOR=0x05; write 0x05 -> 0x80, irq_n=1.
//   Collision: src[1] rising edge in same clk as W1C of bit 1 -> STATUS bit1 remains 1.
//   Masking: pending src[4], ENABLE=0 -> ACTIVE=0, irq_n=1;
//     ENABLE=0x10 -> irq_n low next clk; GIE=0 -> irq_n high.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets, limits and types for the interrupt aggregator.
// No logic and no latency; backpressure not applicable.
package irq_ctrl_pkg;

    localparam logic [2:0] IRQ_STATUS = 3'd0;
    localparam logic [2:0] IRQ_ENABLE = 3'd1;
    localparam logic [2:0] IRQ_MODE   = 3'd2;
    localparam logic [2:0] IRQ_ACTIVE = 3'd3;
    localparam logic [2:0] IRQ_VECTOR = 3'd4;
    localparam logic [2:0] IRQ_CTRL   = 3'd5;

    localparam int IRQ_MAX_SRC = 8;

    typedef logic [7:0] irq_vec_t;

    localparam irq_vec_t VECTOR_NONE = 8'h80;

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: optional sync (IRQ_CTRL_SYNC_EN), sample flop, edge detect, pending flop.
// Latency: src -> pending 1 clk level / 2 clk edge (+2 clk with IRQ_CTRL_SYNC_EN).
// No backpressure; an edge arriving with a clear in the same clk stays pending.
module irq_src_cell (
    input  logic clk,
    input  logic resb,
    input  logic src,
    input  logic mode,
    input  logic clr,
    input  logic mode_clr,
    output logic pending
);

    logic s_in;
    logic s;
    logic s_d;
    logic epend;

`ifdef IRQ_CTRL_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

    assign s_in = sync2;
`else
    assign s_in = src;
`endif

    // Leaving edge mode drops any latched edge so a later return to edge mode starts clean.
    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            s     <= 1'b0;
            s_d   <= 1'b0;
            epend <= 1'b0;
        end else begin
            s   <= s_in;
            s_d <= s;
            if (mode_clr)
                epend <= 1'b0;
            else if (mode && s && !s_d)
                epend <= 1'b1;
            else if (clr)
                epend <= 1'b0;
        end
    end

    assign pending = mode ? epend : s;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt aggregator: register window, fixed lowest-index priority, active-low irq_n to the CPU.
// Latency: reads 1 clk; src edge -> irq_n 3 clk (5 clk with IRQ_CTRL_SYNC_EN defined).
// No backpressure; one register update per cpu_clken-qualified write strobe.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             resb,
    input  logic             cpu_clken,
    input  logic             sel,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    input  logic [N_SRC-1:0] src,
    output logic             irq_n
);

    logic             wr;
    logic [N_SRC-1:0] enable_r;
    logic [N_SRC-1:0] mode_r;
    logic             gie_r;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] mode_clr;

    irq_vec_t status8;
    irq_vec_t enable8;
    irq_vec_t mode8;
    irq_vec_t active8;
    irq_vec_t vector8;
    irq_vec_t rdata;
    logic [2:0] idx;
    logic       none;

    assign wr = sel & we & cpu_clken;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign clr[g] = wr && (((addr == IRQ_STATUS) && din[g]) ||
                               ((addr == IRQ_VECTOR) && (din[2:0] == 3'(g))));
        assign mode_clr[g] = wr && (addr == IRQ_MODE) && mode_r[g] && !din[g];

        irq_src_cell u_cell (
            .clk      (clk),
            .resb     (resb),
            .src      (src[g]),
            .mode     (mode_r[g]),
            .clr      (clr[g]),
            .mode_clr (mode_clr[g]),
            .pending  (pending[g])
        );
    end

    // Scan from the top down so the lowest active index is the one left in idx.
    always_comb begin
        status8 = '0;
        enable8 = '0;
        mode8   = '0;
        status8[N_SRC-1:0] = pending;
        enable8[N_SRC-1:0] = enable_r;
        mode8[N_SRC-1:0]   = mode_r;
        active8 = status8 & enable8;
        idx = 3'd0;
        for (int i = IRQ_MAX_SRC - 1; i >= 0; i--) begin
            if (active8[i])
                idx = 3'(i);
        end
        none    = ~|active8;
        vector8 = none ? VECTOR_NONE : {1'b0, 4'b0000, idx};
        case (addr)
            IRQ_STATUS: rdata = status8;
            IRQ_ENABLE: rdata = enable8;
            IRQ_MODE:   rdata = mode8;
            IRQ_ACTIVE: rdata = active8;
            IRQ_VECTOR: rdata = vector8;
            IRQ_CTRL:   rdata = {7'b0, gie_r};
            default:    rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            enable_r <= '0;
            mode_r   <= '0;
            gie_r    <= 1'b0;
            dout     <= 8'h00;
            irq_n    <= 1'b1;
        end else begin
            if (wr) begin
                case (addr)
                    IRQ_ENABLE: enable_r <= din[N_SRC-1:0];
                    IRQ_MODE:   mode_r   <= din[N_SRC-1:0];
                    IRQ_CTRL:   gie_r    <= din[0];
                    default:    ;
                endcase
            end
            dout  <= rdata;
            irq_n <= ~(gie_r & ~none);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register table, then multi-cycle edge/level/priority/collision/mask/reset sequences.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       resb;
    logic       cpu_clken;
    logic       sel;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] src;
    logic       irq_n;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    typedef struct {
        logic       we;
        logic       clken;
        logic [2:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(8)) dut (
        .clk       (clk),
        .resb      (resb),
        .cpu_clken (cpu_clken),
        .sel       (sel),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .src       (src),
        .irq_n     (irq_n)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    // All bus tasks are entered at a negedge and return at the following negedge.
    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d, input logic ce = 1'b1);
        sel = 1'b1; we = 1'b1; cpu_clken = ce; addr = a; din = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; cpu_clken = 1'b0; din = 8'h00;
    endtask

    task automatic rd_reg(input logic [2:0] a, input logic [7:0] e, input string nm);
        sel = 1'b1; we = 1'b0; cpu_clken = 1'b1; addr = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        sel = 1'b0; cpu_clken = 1'b0;
        check(name_q.pop_front(), dout, exp_q.pop_front());
    endtask

    function automatic vec_t mk(logic w, logic ce, logic [2:0] a, logic [7:0] d, logic [7:0] e);
        vec_t v;
        v.we = w; v.clken = ce; v.addr = a; v.din = d; v.exp = e;
        return v;
    endfunction

    initial begin
        resb = 1'b0; cpu_clken = 1'b0; sel = 1'b0; we = 1'b0;
        addr = 3'd0; din = 8'h00; src = 8'h00;

        // Register table: reset values, RW behaviour, ignored strobes, read-only/unused offsets.
        for (int a = 0; a < 8; a++)
            tbl.push_back(mk(1'b0, 1'b1, 3'(a), 8'h00, (a == 4) ? 8'h80 : 8'h00));
        tbl.push_back(mk(1'b1, 1'b1, IRQ_ENABLE, 8'hA5, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, IRQ_ENABLE, 8'h00, 8'hA5));
        tbl.push_back(mk(1'b1, 1'b0, IRQ_ENABLE, 8'h5A, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, IRQ_ENABLE, 8'h00, 8'hA5));
        tbl.push_back(mk(1'b1, 1'b1, IRQ_MODE,   8'h3C, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, IRQ_MODE,   8'h00, 8'h3C));
        tbl.push_back(mk(1'b1, 1'b1, IRQ_CTRL,   8'hFF, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, IRQ_CTRL,   8'h00, 8'h01));
        tbl.push_back(mk(1'b1, 1'b1, IRQ_ACTIVE, 8'hFF, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, IRQ_ACTIVE, 8'h00, 8'h00));
        tbl.push_back(mk(1'b1, 1'b1, 3'd6,       8'hFF, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd6,       8'h00, 8'h00));
        tbl.push_back(mk(1'b1, 1'b1, 3'd7,       8'hFF, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd7,       8'h00, 8'h00));
        tbl.push_back(mk(1'b1, 1'b1, IRQ_ENABLE, 8'h00, 8'h00));
        tbl.push_back(mk(1'b1, 1'b1, IRQ_MODE,   8'h00, 8'h00));
        tbl.push_back(mk(1'b1, 1'b1, IRQ_CTRL,   8'h00, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, IRQ_CTRL,   8'h00, 8'h00));

        repeat (3) @(negedge clk);
        check("reset_irq_n", {7'b0, irq_n}, 8'h01);
        check("reset_dout", dout, 8'h00);
        resb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_irq_n", {7'b0, irq_n}, 8'h01);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].we)
                wr_reg(tbl[i].addr, tbl[i].din, tbl[i].clken);
            else
                rd_reg(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_addr%0d", i, tbl[i].addr));
        end

        // Edge source 0: one-clk pulse, irq_n falls LAT clks later, W1C releases it.
        wr_reg(IRQ_MODE, 8'h01);
        wr_reg(IRQ_ENABLE, 8'h01);
        wr_reg(IRQ_CTRL, 8'h01);
        src[0] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) src[0] = 1'b0;
            check($sformatf("edge_lat_k%0d", k), {7'b0, irq_n}, (k < LAT) ? 8'h01 : 8'h00);
        end
        rd_reg(IRQ_STATUS, 8'h01, "edge_status");
        rd_reg(IRQ_VECTOR, 8'h00, "edge_vector");
        wr_reg(IRQ_STATUS, 8'h01);
        check("edge_w1c_same", {7'b0, irq_n}, 8'h00);
        @(negedge clk);
        check("edge_w1c_next", {7'b0, irq_n}, 8'h01);

        // Level source 2: follows the pin, W1C has no effect.
        wr_reg(IRQ_MODE, 8'h00);
        wr_reg(IRQ_ENABLE, 8'h04);
        src[2] = 1'b1;
        repeat (LAT) @(negedge clk);
        check("level_irq", {7'b0, irq_n}, 8'h00);
        rd_reg(IRQ_VECTOR, 8'h02, "level_vector");
        wr_reg(IRQ_STATUS, 8'h04);
        rd_reg(IRQ_STATUS, 8'h04, "level_w1c_ignored");
        src[2] = 1'b0;
        for (int k = 1; k <= LAT - 1; k++) begin
            @(negedge clk);
            check($sformatf("level_drop_k%0d", k), {7'b0, irq_n}, (k < LAT - 1) ? 8'h00 : 8'h01);
        end

        // Priority: sources 5 and 3 pending, serviced via VECTOR writes.
        wr_reg(IRQ_MODE, 8'hFF);
        wr_reg(IRQ_ENABLE, 8'hFF);
        src[5] = 1'b1; src[3] = 1'b1;
        @(negedge clk);
        src = 8'h00;
        repeat (LAT - 1) @(negedge clk);
        check("prio_irq", {7'b0, irq_n}, 8'h00);
        rd_reg(IRQ_VECTOR, 8'h03, "prio_vec_first");
        wr_reg(IRQ_VECTOR, 8'h03);
        rd_reg(IRQ_VECTOR, 8'h05, "prio_vec_second");
        rd_reg(IRQ_ACTIVE, 8'h20, "prio_active");
        wr_reg(IRQ_VECTOR, 8'h05);
        rd_reg(IRQ_VECTOR, 8'h80, "prio_vec_none");
        check("prio_irq_released", {7'b0, irq_n}, 8'h01);

        // Collision: W1C of bit 1 lands in the same clk the edge sets it.
        src[1] = 1'b1;
        repeat (LAT - 2) @(negedge clk);
        wr_reg(IRQ_STATUS, 8'h02);
        rd_reg(IRQ_STATUS, 8'h02, "collision_set_wins");
        check("collision_irq", {7'b0, irq_n}, 8'h00);
        wr_reg(IRQ_STATUS, 8'h02);
        rd_reg(IRQ_STATUS, 8'h00, "collision_later_clear");
        src[1] = 1'b0;

        // Masking: pending source 4 gated by ENABLE then by GIE.
        wr_reg(IRQ_ENABLE, 8'h00);
        src[4] = 1'b1;
        @(negedge clk);
        src[4] = 1'b0;
        repeat (LAT) @(negedge clk);
        rd_reg(IRQ_ACTIVE, 8'h00, "mask_active");
        rd_reg(IRQ_STATUS, 8'h10, "mask_status");
        check("mask_irq_off", {7'b0, irq_n}, 8'h01);
        wr_reg(IRQ_ENABLE, 8'h10);
        check("mask_en_same", {7'b0, irq_n}, 8'h01);
        @(negedge clk);
        check("mask_en_next", {7'b0, irq_n}, 8'h00);
        wr_reg(IRQ_CTRL, 8'h00);
        check("mask_gie_same", {7'b0, irq_n}, 8'h00);
        @(negedge clk);
        check("mask_gie_next", {7'b0, irq_n}, 8'h01);
        rd_reg(IRQ_STATUS, 8'h10, "mask_pending_kept");

        // MODE 1->0 discards the latched edge; returning to edge mode does not revive it.
        wr_reg(IRQ_MODE, 8'hEF);
        rd_reg(IRQ_STATUS, 8'h00, "mode_clr_level");
        wr_reg(IRQ_MODE, 8'hFF);
        rd_reg(IRQ_STATUS, 8'h00, "mode_clr_edge");

        // Async reset while irq_n is asserted.
        wr_reg(IRQ_CTRL, 8'h01);
        src[4] = 1'b1;
        @(negedge clk);
        src[4] = 1'b0;
        repeat (LAT) @(negedge clk);
        check("arst_pre_irq", {7'b0, irq_n}, 8'h00);
        #2 resb = 1'b0;
        #1 check("arst_irq_n", {7'b0, irq_n}, 8'h01);
        @(negedge clk);
        resb = 1'b1;
        rd_reg(IRQ_STATUS, 8'h00, "arst_status");
        rd_reg(IRQ_ENABLE, 8'h00, "arst_enable");
        rd_reg(IRQ_CTRL, 8'h00, "arst_ctrl");
        rd_reg(IRQ_VECTOR, 8'h80, "arst_vector");
        check("arst_irq_after", {7'b0, irq_n}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
